// File: rtl/flappy_pkg.sv
// flappy_pkg: shared FSM state type, coordinate widths and default screen geometry for the pipe spawner.
package flappy_pkg;
   typedef enum logic [1:0] {IDLE, SPAWN, RUN, HALT} state_t;
   localparam int X_W = 11;
   localparam int Y_W = 9;
   localparam int DEF_NUM_PIPES = 3;
   localparam int DEF_SCREEN_W = 640;
   localparam int DEF_SPACING = 240;
   localparam int DEF_SPEED = 2;
   localparam int DEF_GAP_MIN = 80;
   localparam int DEF_GAP_RANGE = 200;
   localparam int DEF_BIRD_X = 160;
endpackage

// File: rtl/pipe_spawner_if.sv
// pipe_spawner_if: control, LFSR and pipe-state bundle around the spawner.
// PIPE_SPAWNER_SCORE_EN adds the score output.
interface pipe_spawner_if
   import flappy_pkg::*;
   #(parameter int NUM_PIPES = DEF_NUM_PIPES);
   logic start, stop, tick;
   logic [7:0] rand_byte;
   logic lfsr_en, pipes_valid, pass_pulse;
   logic [NUM_PIPES*X_W-1:0] pipe_x;
   logic [NUM_PIPES*Y_W-1:0] pipe_gap;
`ifdef PIPE_SPAWNER_SCORE_EN
   logic [7:0] score;
   modport master (output start, stop, tick, rand_byte,
                   input lfsr_en, pipes_valid, pass_pulse, pipe_x, pipe_gap, score);
   modport slave (input start, stop, tick, rand_byte,
                  output lfsr_en, pipes_valid, pass_pulse, pipe_x, pipe_gap, score);
`else
   modport master (output start, stop, tick, rand_byte,
                   input lfsr_en, pipes_valid, pass_pulse, pipe_x, pipe_gap);
   modport slave (input start, stop, tick, rand_byte,
                  output lfsr_en, pipes_valid, pass_pulse, pipe_x, pipe_gap);
`endif
endinterface

// File: rtl/pipe_slot.sv
// pipe_slot: one pipe's x/gap registers with scroll, wrap-around respawn and bird pass detection.
module pipe_slot
   import flappy_pkg::*;
   #(
   parameter int INIT_X = 640,
   parameter int SPEED = 2,
   parameter int WRAP_ADD = 718,
   parameter int BIRD_X = 160
   ) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic           move,
   input  logic [Y_W-1:0] new_gap,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] gap,
   output logic           wrap,
   output logic           pass
);
   assign wrap = move && x < X_W'(SPEED);
   assign pass = move && !wrap && x >= X_W'(BIRD_X) && x - X_W'(SPEED) < X_W'(BIRD_X);
   // WRAP_ADD folds the -SPEED step in so x never underflows
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         x <= '0;
         gap <= '0;
      end else if (load) begin
         x <= X_W'(INIT_X);
         gap <= new_gap;
      end else if (wrap) begin
         x <= x + X_W'(WRAP_ADD);
         gap <= new_gap;
      end else if (move)
         x <= x - X_W'(SPEED);
endmodule

// File: rtl/pipe_spawner.sv
// pipe_spawner: spawns and scrolls NUM_PIPES pipes, drawing gap heights from the LFSR byte.
// Define PIPE_SPAWNER_SCORE_EN to add a saturating pass counter on bus.score.
module pipe_spawner
   import flappy_pkg::*;
   #(
   parameter int NUM_PIPES = DEF_NUM_PIPES,
   parameter int SCREEN_W = DEF_SCREEN_W,
   parameter int SPACING = DEF_SPACING,
   parameter int SPEED = DEF_SPEED,
   parameter int GAP_MIN = DEF_GAP_MIN,
   parameter int GAP_RANGE = DEF_GAP_RANGE,
   parameter int BIRD_X = DEF_BIRD_X
   ) (
   input logic clk,
   input logic reset,
   pipe_spawner_if.slave bus
);
   localparam int IDX_W = NUM_PIPES > 1 ? $clog2(NUM_PIPES) : 1;
   state_t state_q, state_d;
   logic [IDX_W-1:0] idx;
   logic spawn_we, move;
   logic [Y_W-1:0] rb, new_gap;
   logic [NUM_PIPES-1:0] wrap, pass;
   assign rb = Y_W'(bus.rand_byte);
   assign new_gap = Y_W'(GAP_MIN) + (rb >= Y_W'(GAP_RANGE) ? rb - Y_W'(GAP_RANGE) : rb);
   assign bus.lfsr_en = spawn_we | (|wrap);
   assign bus.pipes_valid = state_q == RUN || state_q == HALT;
   always_comb begin
      state_d = state_q;
      spawn_we = 1'b0;
      move = 1'b0;
      if (bus.stop && state_q != IDLE) state_d = HALT;
      else
         case (state_q)
            IDLE: state_d = bus.start ? SPAWN : IDLE;
            SPAWN: begin
               spawn_we = 1'b1;
               state_d = idx == IDX_W'(NUM_PIPES - 1) ? RUN : SPAWN;
            end
            RUN: move = bus.tick;
            HALT: state_d = bus.start ? SPAWN : HALT;
         endcase
   end
   // idx rests at 0 outside SPAWN, so every spawn run begins at slot 0
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         idx <= '0;
         bus.pass_pulse <= 1'b0;
      end else begin
         state_q <= state_d;
         idx <= (spawn_we && idx != IDX_W'(NUM_PIPES - 1)) ? idx + 1'b1 : '0;
         bus.pass_pulse <= |pass;
      end
   for (genvar i = 0; i < NUM_PIPES; i++) begin : g_slot
      pipe_slot #(
         .INIT_X(SCREEN_W + i * SPACING),
         .SPEED(SPEED),
         .WRAP_ADD(NUM_PIPES * SPACING - SPEED),
         .BIRD_X(BIRD_X)
      ) u_slot (
         .clk(clk),
         .reset(reset),
         .load(spawn_we && idx == IDX_W'(i)),
         .move(move),
         .new_gap(new_gap),
         .x(bus.pipe_x[i*X_W +: X_W]),
         .gap(bus.pipe_gap[i*Y_W +: Y_W]),
         .wrap(wrap[i]),
         .pass(pass[i])
      );
   end
`ifdef PIPE_SPAWNER_SCORE_EN
   always_ff @(posedge clk or posedge reset)
      if (reset) bus.score <= '0;
      else if (state_d == SPAWN && state_q != SPAWN) bus.score <= '0;
      else if (|pass && bus.score != 8'hFF) bus.score <= bus.score + 8'd1;
`endif
   always_ff @(posedge clk)
      if (!reset) assert ($onehot0(wrap)) else $error("pipe_spawner: several pipes wrapped in one tick");
endmodule
